ysyx_24110015_inst_queue: RTL and testbench

//   Instruction queue between IFU and IDU. Buffers fetched {pc, inst} pairs in a

---
 rtl/ysyx_24110015_inst_queue.sv | 114 +++++++++++
 tb/tb_ysyx_24110015_inst_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_inst_queue.sv
// ysyx_24110015_inst_queue
//   Instruction queue between IFU and IDU. It holds {pc, inst} pairs in a
//   DEPTH-entry circular buffer with valid/ready handshakes on both sides.
//   A redirect flush drops every buffered entry in one cycle.
//
//   Optional build macro: IQ_BYPASS_EN
//     defined   : when the queue is empty, an incoming pair is presented on
//                 out_* in the same cycle. If the IDU takes it, the pair is
//                 never written into storage.
//     undefined : out_* come only from storage, so latency is always 1 cycle.
//
//   Only pointers and occupancy are reset. Storage is left unreset because
//   out_* are forced to zero whenever the queue is empty.
module ysyx_24110015_inst_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wr_en;
  logic byp_act;
  logic byp_take;

  assign empty = (cnt == '0);
  assign full  = (cnt == (PTR_W+1)'(DEPTH));

  // Ready depends only on occupancy, flush and reset. It never depends on
  // out_ready, so IFU and IDU cannot form a combinational loop through here.
  assign in_ready = rst & ~full & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = ~empty & out_ready;

`ifdef IQ_BYPASS_EN
  assign byp_act  = rst & empty & in_valid & ~flush;
  assign byp_take = byp_act & out_ready;
`else
  assign byp_act  = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A pair consumed through the bypass is never written into storage.
  assign wr_en = push & ~byp_take;
  assign count = cnt;

  // Head selection: the stored head wins, then the bypass, otherwise zeros.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = '0;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = pc_mem[rd_ptr];
      out_inst  = inst_mem[rd_ptr];
    end else if (byp_act) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
  end

  // Pointers and occupancy. Flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
    end
  end

  // Storage write. wr_en already excludes flush, full and reset through in_ready.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  // Occupancy must stay within 0..DEPTH, and a full queue must never be written.
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst)
    cnt <= (PTR_W+1)'(DEPTH));
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(full && wr_en));

endmodule

// File: tb/tb_ysyx_24110015_inst_queue.sv
// Self-checking bench for ysyx_24110015_inst_queue: directed scenarios followed
// by a randomized run, all checked against a queue-based reference model.
module tb_ysyx_24110015_inst_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic [PTR_W:0]   count;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mq[$];

  ysyx_24110015_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: expected {valid, pc, inst} seen by the IDU right now.
  function automatic logic [64:0] exp_out();
    if (mq.size() != 0) return {1'b1, mq[0]};
`ifdef IQ_BYPASS_EN
    if (rst && in_valid && !flush) return {1'b1, in_pc, in_inst};
`endif
    return '0;
  endfunction

  // Advance one clock and apply the queue rules to the model.
  task automatic cycle();
    bit p, q_pop, take;
    p     = in_valid && rst && !flush && (mq.size() < DEPTH);
    q_pop = rst && (mq.size() != 0) && out_ready;
    take  = 1'b0;
`ifdef IQ_BYPASS_EN
    take  = p && (mq.size() == 0) && out_ready;
`endif
    @(posedge clk);
    if (!rst) mq.delete();
    else if (flush) mq.delete();
    else begin
      if (q_pop) void'(mq.pop_front());
      if (p && !take) mq.push_back({in_pc, in_inst});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_pc    = 32'h1234_5678;
    in_inst  = 32'h0000_0013;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h/%h expected 0/0", out_pc, out_inst); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_push();
    in_valid  = 1'b1;
    in_pc     = 32'h8000_0000;
    in_inst   = 32'h0000_0413;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 32'h8000_0000) begin failures++; $display("FAIL single_pc: got %h expected 80000000", out_pc); end
    checks++; if (out_inst !== 32'h0000_0413) begin failures++; $display("FAIL single_inst: got %h expected 00000413", out_inst); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", count); end
    drain();
  endtask

  task automatic test_fill_full();
    logic [31:0] pcs [DEPTH];
    logic [31:0] insts [DEPTH];
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pcs[i]   = 32'h8000_1000 + 32'(4 * i);
      insts[i] = $urandom;
      in_valid = 1'b1;
      in_pc    = pcs[i];
      in_inst  = insts[i];
      cycle();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b1;
    in_pc    = 32'hDEAD_BEEF;
    in_inst  = 32'hFFFF_FFFF;
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_blocked_count: got %0d expected 4", count); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_pc !== pcs[0]) begin failures++; $display("FAIL full_head: got %h expected %h", out_pc, pcs[0]); end
    cycle();
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL after_pop_in_ready: got %b expected 1", in_ready); end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL after_pop_count: got %0d expected 3", count); end
    for (int i = 1; i < DEPTH; i++) begin
      out_ready = 1'b1;
      #1;
      checks++; if (out_pc !== pcs[i] || out_inst !== insts[i]) begin failures++; $display("FAIL order_%0d: got %h/%h expected %h/%h", i, out_pc, out_inst, pcs[i], insts[i]); end
      cycle();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drained_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] base;
    base      = 32'h8000_0000;
    in_valid  = 1'b1;
    in_pc     = base;
    in_inst   = $urandom;
    out_ready = 1'b0;
    cycle();
    for (int k = 1; k <= 10; k++) begin
      in_pc     = base + 32'(4 * k);
      in_inst   = $urandom;
      out_ready = 1'b1;
      #1;
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count_%0d: got %0d expected 1", k, count); end
      checks++; if (out_pc !== base + 32'(4 * (k - 1))) begin failures++; $display("FAIL stream_pc_%0d: got %h expected %h", k, out_pc, base + 32'(4 * (k - 1))); end
      cycle();
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h8000_2000 + 32'(4 * i);
      in_inst  = $urandom;
      cycle();
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    in_pc    = 32'h8000_2FFC;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    in_valid = 1'b1;
    in_pc    = 32'h8000_3000;
    in_inst  = 32'h0000_0073;
    cycle();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL post_flush_count: got %0d expected 1", count); end
    checks++; if (out_pc !== 32'h8000_3000 || out_inst !== 32'h0000_0073) begin failures++; $display("FAIL post_flush_head: got %h/%h expected 80003000/00000073", out_pc, out_inst); end
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h8000_4000 + 32'(4 * i);
      in_inst  = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    mq.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL arst_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_hold_in_ready: got %b expected 0", in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_release_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    in_valid  = 1'b1;
    in_pc     = 32'h8000_5000;
    in_inst   = 32'h0010_0093;
    out_ready = 1'b1;
    #1;
`ifdef IQ_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0010_0093) begin failures++; $display("FAIL bypass_out: got %b/%h expected 1/00100093", out_valid, out_inst); end
`else
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL no_bypass_out: got %b expected 0", out_valid); end
`endif
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
`ifdef IQ_BYPASS_EN
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL no_bypass_count: got %0d expected 1", count); end
`endif
    drain();
  endtask

  task automatic test_random();
    logic [64:0] e;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      in_pc     = $urandom;
      in_inst   = $urandom;
      #1;
      e = exp_out();
      checks++; if (in_ready !== ((mq.size() < DEPTH) && !flush)) begin failures++; $display("FAIL rand_in_ready_%0d: got %b expected %b", n, in_ready, (mq.size() < DEPTH) && !flush); end
      checks++; if (count !== (PTR_W+1)'(mq.size())) begin failures++; $display("FAIL rand_count_%0d: got %0d expected %0d", n, count, mq.size()); end
      checks++; if (out_valid !== e[64]) begin failures++; $display("FAIL rand_valid_%0d: got %b expected %b", n, out_valid, e[64]); end
      checks++; if ({out_pc, out_inst} !== e[63:0]) begin failures++; $display("FAIL rand_data_%0d: got %h/%h expected %h/%h", n, out_pc, out_inst, e[63:32], e[31:0]); end
      cycle();
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    #1;
    rst = 1'b0;
    test_reset();
    @(negedge clk);
    test_single_push();
    test_fill_full();
    test_stream();
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
